stream_mux_arb: RTL



---
 rtl/stream_mux_arb_pkg.sv | 14 +
 rtl/stream_mux_arb_rr_arbiter.sv | 30 +++
 rtl/stream_mux_arb.sv | 113 +++++++++++
 3 files changed

// File: rtl/stream_mux_arb_pkg.sv
// Shared definitions for the stream_mux_arb slice: arbitration mode
// encodings and the channel-index width helper.
package stream_mux_arb_pkg;

  localparam int MODE_RR   = 0;
  localparam int MODE_PRIO = 1;
  localparam int MODE_SEL  = 2;

  // A single channel still needs a one-bit index.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_mux_arb_rr_arbiter.sv
// Combinational rotating-priority arbiter: the first requester at or after
// ptr wins, wrapping N-1 -> 0. Tying ptr to zero gives fixed priority.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int SELW = 2
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_valid
);

  int w_idx;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    w_idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      w_idx = int'(ptr) + k;
      if (w_idx >= N) w_idx = w_idx - N;
      if (req[w_idx]) begin
        gnt_idx   = SELW'(w_idx);
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_mux_arb.sv
// N-channel streaming multiplexer with valid/ready handshakes, a registered
// output stage and packet-locked grants (round-robin, priority or select).
module stream_mux_arb
  import stream_mux_arb_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int N     = 4,
  parameter  int MODE  = 0,
  localparam int SELW  = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_last,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Handshake: a beat moves on any rising edge where valid and ready are
  // both high; valid never waits on ready, and a producer holds its beat
  // stable until accepted. in_ready is combinational from out_ready.

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;
  logic [SELW-1:0]  r_out_ch;
  logic             r_out_valid;
  logic             r_lock;
  logic [SELW-1:0]  r_lock_ch;
  logic [SELW-1:0]  r_rr_ptr;

  logic             w_load_en;
  logic [SELW-1:0]  w_arb_ptr;
  logic [SELW-1:0]  w_arb_idx;
  logic             w_arb_valid;
  logic [SELW-1:0]  w_g;
  logic             w_gv;
  logic             w_xfer;
  logic [WIDTH-1:0] w_data;
  logic             w_last;

  assign w_load_en = !r_out_valid | out_ready;
  assign w_arb_ptr = (MODE == MODE_PRIO) ? '0 : r_rr_ptr;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_arb (
    .req       (in_valid),
    .ptr       (w_arb_ptr),
    .gnt_idx   (w_arb_idx),
    .gnt_valid (w_arb_valid)
  );

  // A locked packet owns the output; sel and other requesters are ignored.
  always_comb begin
    w_g  = '0;
    w_gv = 1'b0;
    if (r_lock) begin
      w_g  = r_lock_ch;
      w_gv = in_valid[r_lock_ch];
    end else if (MODE == MODE_SEL) begin
      w_g  = sel;
      w_gv = (int'(sel) < N) ? in_valid[sel] : 1'b0;
    end else begin
      w_g  = w_arb_idx;
      w_gv = w_arb_valid;
    end
  end

  assign w_xfer   = w_gv & w_load_en;
  assign w_data   = in_data[int'(w_g)*WIDTH +: WIDTH];
  assign w_last   = in_last[w_g];
  assign in_ready = w_xfer ? (N'(1) << w_g) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
      r_out_ch    <= '0;
      r_out_valid <= 1'b0;
      r_lock      <= 1'b0;
      r_lock_ch   <= '0;
      r_rr_ptr    <= '0;
    end else if (w_xfer) begin
      r_out_data  <= w_data;
      r_out_last  <= w_last;
      r_out_ch    <= w_g;
      r_out_valid <= 1'b1;
      if (w_last) begin
        r_lock <= 1'b0;
        if (MODE == MODE_RR)
          r_rr_ptr <= (int'(w_g) == N - 1) ? '0 : w_g + SELW'(1);
      end else begin
        r_lock    <= 1'b1;
        r_lock_ch <= w_g;
      end
    end else if (out_ready & r_out_valid) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign out_ch    = r_out_ch;
  assign out_valid = r_out_valid;

endmodule
